// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared constants and helpers for the 4x4 matrix keypad scanner.
//   ROWS, COLS, KEY_W : matrix geometry; key vector bit index = row*COLS + col
//   key_class_e       : classification of a debounced key vector
//   key_idx()         : flat key index of a (row, col) pair
//   popcount16()      : number of set bits in a key vector
//   classify()        : none / single / multiple keys down
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = ROWS * COLS;

    typedef enum logic [1:0] {
        KEY_NONE   = 2'd0,
        KEY_SINGLE = 2'd1,
        KEY_MULTI  = 2'd2
    } key_class_e;

    function automatic logic [3:0] key_idx(input logic [1:0] r, input logic [1:0] c);
        return 4'(int'(r) * COLS + int'(c));
    endfunction

    function automatic logic [4:0] popcount16(input logic [KEY_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEY_W; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic key_class_e classify(input logic [KEY_W-1:0] v);
        logic [4:0] n;
        n = popcount16(v);
        if (n == 5'd0) begin
            return KEY_NONE;
        end else if (n == 5'd1) begin
            return KEY_SINGLE;
        end else begin
            return KEY_MULTI;
        end
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
// Frame-level debouncer. Each complete scan frame is compared with the one
// before it; a frame value is accepted once it has been seen in
// DEBOUNCE_FRAMES consecutive frames. The accepted value is then reduced to a
// one-hot key vector (single key only) or a multi-key flag.
//   clk, rst_n : clock, synchronous active-low reset
//   frame_stb  : one-cycle pulse, frame holds a complete scan frame
//   frame      : raw (active-high) key matrix of the completed frame
//   onehot     : accepted single key, zero for no key or several keys
//   key_valid  : one-cycle strobe when onehot moves to a new nonzero key
//   key_multi  : accepted frame has two or more keys down
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_stb,
    input  logic [KEY_W-1:0] frame,
    output logic [KEY_W-1:0] onehot,
    output logic             key_valid,
    output logic             key_multi
);

    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] S_MAX = SW'(DEBOUNCE_FRAMES);

    logic [KEY_W-1:0] prev_frame;
    logic [KEY_W-1:0] accepted;
    logic [KEY_W-1:0] accepted_nxt;
    logic [KEY_W-1:0] onehot_nxt;
    logic [SW-1:0]    stable;
    logic [SW-1:0]    stable_nxt;
    logic             multi_nxt;
    key_class_e       cls;

    // Outputs are computed from the value the accepted register is about to
    // take, so they appear one cycle after the frame strobe instead of two.
    always_comb begin
        stable_nxt   = stable;
        accepted_nxt = accepted;
        if (frame_stb) begin
            if (frame == prev_frame) begin
                stable_nxt = (stable == S_MAX) ? S_MAX : stable + SW'(1);
            end else begin
                stable_nxt = SW'(1);
            end
            if (stable_nxt == S_MAX) begin
                accepted_nxt = frame;
            end
        end
        cls        = classify(accepted_nxt);
        onehot_nxt = (cls == KEY_SINGLE) ? accepted_nxt : '0;
        multi_nxt  = (cls == KEY_MULTI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_frame <= '0;
            stable     <= '0;
            accepted   <= '0;
            onehot     <= '0;
            key_valid  <= 1'b0;
            key_multi  <= 1'b0;
        end else begin
            if (frame_stb) begin
                prev_frame <= frame;
            end
            stable    <= stable_nxt;
            accepted  <= accepted_nxt;
            onehot    <= onehot_nxt;
            key_multi <= multi_nxt;
            // A held key keeps onehot unchanged, so it never re-strobes;
            // release drives onehot to zero, which never strobes either.
            key_valid <= (onehot_nxt != '0) && (onehot_nxt != onehot);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner. Drives one row low at a time for SCAN_DIV
// cycles, samples the synchronized active-low columns at the end of each
// dwell, assembles a 16-bit frame and hands complete frames to the debouncer.
//   clk, rst_n : clock, synchronous active-low reset
//   row        : row drive, active-low, exactly one bit low
//   col        : column sense, active-low, asynchronous to clk
//   onehot     : accepted key vector, bit = row*4 + col
//   key_valid  : one-cycle strobe on a new single-key press
//   key_multi  : accepted frame has two or more keys down
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [ROWS-1:0]  row,
    input  logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] onehot,
    output logic             key_valid,
    output logic             key_multi
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(SCAN_DIV - 1);

    logic [COLS-1:0]  col_meta;
    logic [COLS-1:0]  col_sync;
    logic [1:0]       row_idx;
    logic [DW-1:0]    dwell;
    logic [KEY_W-1:0] frame_acc;
    logic             frame_stb;
    logic             row_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    assign row_done = (dwell == D_LAST);

    // Sampling at the last dwell cycle leaves SCAN_DIV-1 cycles for the column
    // lines and the synchronizer to settle after each row change. The row
    // drive is registered so it always equals the decode of row_idx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_idx   <= 2'd0;
            dwell     <= '0;
            row       <= 4'b1110;
            frame_acc <= '0;
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            if (row_done) begin
                dwell <= '0;
                frame_acc[key_idx(row_idx, 2'd0) +: COLS] <= ~col_sync;
                row_idx   <= row_idx + 2'd1;
                row       <= ~(4'b0001 << (row_idx + 2'd1));
                frame_stb <= (row_idx == 2'(ROWS - 1));
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // frame_acc is stable for SCAN_DIV cycles after the strobe (row 0 is not
    // rewritten until its own dwell ends), so the debouncer reads it directly.
    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_stb (frame_stb),
        .frame     (frame_acc),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_multi (key_multi)
    );

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the 4x4 matrix keypad, debounces it, and produces the 16-bit one-hot key vector that feeds the one-hot-to-binary digit encoder directly downstream. It drives one row low at a time and samples the active-low column lines. A key is accepted only after it is stable for several full scan frames. The block emits a one-hot vector for single-key presses and a one-cycle strobe for each new press.

## Interface
- SCAN_DIV, 50000: clock cycles each row is driven (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames required before acceptance; minimum 1.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- row  out  4  row drive, active-low, exactly one bit low at any time.
- col  in  4  column sense, active-low (pulled up), asynchronous to clk.
- onehot  out  16  accepted key vector; bit index = row*4 + col; all-zero when no key is pressed or when more than one key is pressed.
- key_valid  out  1  one-cycle strobe on a new accepted single-key press.
- key_multi  out  1  high while the accepted frame has two or more keys down.

## Operation
- col passes through a 2-flop synchronizer. Synchronizer reset value is 4'b1111.
- Row index r (0..3) and dwell counter d (0..SCAN_DIV-1).
  - row = ~(4'b0001 << r).
  - d increments every cycle.
  - At d == SCAN_DIV-1: sample inverted synchronized col into frame bits [r*4+3 : r*4], set d = 0, then r = r+1 with wrap 3 -> 0.
- Sampling at the end of the dwell gives more than 2 cycles of settle time after each row change.
- Frame complete when row 3 is sampled. The new frame value F is compared with the previous frame P:
  - F == P: stable count s = min(s+1, DEBOUNCE_FRAMES).
  - F != P: s = 1.
  - In both cases P <= F.
- When s reaches DEBOUNCE_FRAMES, the accepted value A <= F.
- From A:
  - popcount(A) == 1: onehot = A, key_multi = 0.
  - popcount(A) == 0: onehot = 0, key_multi = 0.
  - popcount(A) >= 2: onehot = 0, key_multi = 1.
- key_valid = 1 for one cycle when onehot changes to a nonzero value different from its previous value.
  - A held key gives no repeat strobe.
  - Switching directly from key X to key Y strobes once.
- Counter widths are $clog2(SCAN_DIV) and $clog2(DEBOUNCE_FRAMES+1). Widths are unsigned and there is no overflow, because d wraps explicitly and s saturates.

## Timing
- Reset values: row = 4'b1110, onehot = 16'h0000, key_valid = 0, key_multi = 0, r = d = s = 0, P = A = 0.
- Frame period is 4*SCAN_DIV cycles.
- onehot, key_multi and key_valid update 1 cycle after the sampling edge of row 3. All outputs are registered.
- Press-to-onehot latency is between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames, plus 3 cycles (synchronizer plus output register).
- A bounce inside the debounce window restarts s at 1, so there is no partial acceptance.
- Release follows the same rule: onehot returns to 0 after DEBOUNCE_FRAMES stable all-zero frames. No strobe is issued on release.
- rst_n low mid-frame aborts the frame. The next cycle shows reset values, and scanning restarts at row 0, d = 0.
- Downstream holds its last digit while onehot = 0, so no extra hold logic is needed here.

## Structure
- Shared package keypad_pkg:
  - ROWS = 4, COLS = 4.
  - KEY_W = 16.
  - function key_idx(row, col) = row*COLS + col.
  - popcount function for 16 bits.
- One sub-module, keypad_debounce: frame compare, stable counter, accepted-value register, popcount classification and key_valid generation. Parameter: DEBOUNCE_FRAMES.
- The top level holds the synchronizer, the row/dwell counters and frame assembly.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_FRAMES = 2; the keypad model shorts row r to col c.
- Reset: hold rst_n = 0 for 5 cycles -> row = 1110, onehot = 0, key_valid = 0. After release, row walks 1110 -> 1101 -> 1011 -> 0111, 4 cycles each.
- Clean press of r=0, c=3 -> onehot = 16'h0008 within 3 frames; key_valid high for exactly 1 cycle; holding for 10 frames gives no further strobe.
- Bouncy press of r=1, c=1, toggling for 1.5 frames then stable -> a single key_valid; onehot = 16'h0020 only after 2 stable frames.
- Two keys (0,3) and (2,1) held -> onehot = 0, key_multi = 1, no key_valid. After releasing (2,1): onehot = 16'h0008, key_multi = 0, key_valid pulses.
- Roll from (3,2) directly to (3,3) -> onehot 16'h4000 then 16'h8000, with one strobe each. Release -> onehot = 0 and no strobe.
- rst_n = 0 for 1 cycle mid-debounce of key (1,2) -> outputs reset, and acceptance requires 2 full fresh frames afterward.
